// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: ALU write port, divide request, and the registered HI/LO result with divide status.
// The master side is the ALU/pipeline; the slave side is hilo_unit.
interface hilo_unit_if;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        start_div;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] hilo_q;
  logic        busy;
  logic        div_done;
  logic        div_by_zero;

  modport master (
    output wr_en, wr_data, start_div, div_signed, dividend, divisor,
    input  hilo_q, busy, div_done, div_by_zero
  );

  modport slave (
    input  wr_en, wr_data, start_div, div_signed, dividend, divisor,
    output hilo_q, busy, div_done, div_by_zero
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair with optional iterative restoring divider, enabled by macro HILO_ITER_DIV_EN.
// Latency: write 1 cycle; divide result lands 34 cycles after the start edge.
// Backpressure: busy stalls the pipeline; wr_en and start_div are dropped while busy.
module hilo_unit (
  input logic        clk_cpu,
  input logic        reset,
  hilo_unit_if.slave bus
);

`ifdef HILO_ITER_DIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] hilo_dat_q, hilo_dat_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        sgn_dvd_q, sgn_dvd_d;
  logic        sgn_dvs_q, sgn_dvs_d;
  logic        prime_q, prime_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic [32:0] shift_rem;
  logic [32:0] trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    state_d    = state_q;
    hilo_dat_d = hilo_dat_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    sgn_dvd_d  = sgn_dvd_q;
    sgn_dvs_d  = sgn_dvs_q;
    prime_d    = prime_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    shift_rem = {rem_q, quo_q[31]};
    trial     = shift_rem - {1'b0, dvs_q};
    quo_fix   = (sgn_dvd_q ^ sgn_dvs_q) ? -quo_q : quo_q;
    rem_fix   = sgn_dvd_q ? -rem_q : rem_q;
    // Divide-by-zero returns an all-ones quotient regardless of signs.
    if (dvs_q == '0) begin
      quo_fix = '1;
    end

    case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          hilo_dat_d = bus.wr_data;
        end
        if (bus.start_div) begin
          sgn_dvd_d = bus.div_signed & bus.dividend[31];
          sgn_dvs_d = bus.div_signed & bus.divisor[31];
          dvd_d     = sgn_dvd_d ? -bus.dividend : bus.dividend;
          dvs_d     = sgn_dvs_d ? -bus.divisor : bus.divisor;
          cnt_d     = '0;
          prime_d   = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        // First CALC cycle seeds the working registers; the next 32 are the divide steps.
        if (prime_q) begin
          rem_d   = '0;
          quo_d   = dvd_q;
          prime_d = 1'b0;
        end else begin
          if (shift_rem >= {1'b0, dvs_q}) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shift_rem[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        hilo_dat_d = {rem_fix, quo_fix};
        done_d     = 1'b1;
        dbz_d      = (dvs_q == '0);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hilo_dat_q <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      sgn_dvd_q  <= 1'b0;
      sgn_dvs_q  <= 1'b0;
      prime_q    <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hilo_dat_q <= hilo_dat_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      sgn_dvd_q  <= sgn_dvd_d;
      sgn_dvs_q  <= sgn_dvs_d;
      prime_q    <= prime_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.hilo_q      = hilo_dat_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.div_done    = done_q;
  assign bus.div_by_zero = dbz_q;

`else
  // The ALU computes div/divu itself in this build, so only the write path remains.
  logic [63:0] hilo_dat_q, hilo_dat_d;
  logic        unused_div_inputs;

  assign unused_div_inputs = ^{bus.start_div, bus.div_signed, bus.dividend, bus.divisor};

  always_comb begin
    hilo_dat_d = hilo_dat_q;
    if (bus.wr_en) begin
      hilo_dat_d = bus.wr_data;
    end
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      hilo_dat_q <= '0;
    end else begin
      hilo_dat_q <= hilo_dat_d;
    end
  end

  assign bus.hilo_q      = hilo_dat_q;
  assign bus.busy        = 1'b0;
  assign bus.div_done    = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit; divide scenarios are exercised when HILO_ITER_DIV_EN is defined.
module tb_hilo_unit;
  logic        clk_cpu = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_hilo;

  hilo_unit_if bus ();

  hilo_unit dut (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic tick();
    @(negedge clk_cpu);
  endtask

  task automatic idle_inputs();
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.start_div  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();
    model_hilo = '0;
    checks++;
    if (bus.hilo_q !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h expected 0", bus.hilo_q);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.div_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus.div_done);
    end
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero);
    end
    reset = 1'b1;
  endtask

  task automatic test_write();
    logic        wr;
    logic [63:0] wd;
    bus.wr_en   = 1'b1;
    bus.wr_data = 64'h12345678_9ABCDEF0;
    tick();
    idle_inputs();
    model_hilo = 64'h12345678_9ABCDEF0;
    checks++;
    if (bus.hilo_q !== 64'h12345678_9ABCDEF0) begin
      errors++;
      $display("FAIL write_directed: got %h expected 123456789abcdef0", bus.hilo_q);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL write_busy: got %b expected 0", bus.busy);
    end
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      bus.wr_en   = wr;
      bus.wr_data = wd;
      tick();
      idle_inputs();
      if (wr) model_hilo = wd;
      checks++;
      if (bus.hilo_q !== model_hilo) begin
        errors++;
        $display("FAIL write_random[%0d]: got %h expected %h", i, bus.hilo_q, model_hilo);
      end
    end
  endtask

`ifdef HILO_ITER_DIV_EN
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int          sa;
    int          sb;
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'h0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
    return {r, q};
  endfunction

  task automatic do_divide(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input logic with_wr, input logic collide);
    logic [63:0] wd;
    int          busy_bad;
    int          hold_bad;
    int          done_bad;
    wd = {$urandom, $urandom};
    bus.start_div  = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.wr_en      = with_wr;
    bus.wr_data    = wd;
    tick();
    idle_inputs();
    if (with_wr) begin
      model_hilo = wd;
      checks++;
      if (bus.hilo_q !== wd) begin
        errors++;
        $display("FAIL %s_same_edge_write: got %h expected %h", name, bus.hilo_q, wd);
      end
    end
    busy_bad = 0;
    hold_bad = 0;
    done_bad = 0;
    for (int k = 0; k < 34; k++) begin
      if (k > 0) begin
        if (collide && k == 10) begin
          bus.wr_en      = 1'b1;
          bus.wr_data    = {$urandom, $urandom};
          bus.start_div  = 1'b1;
          bus.div_signed = ~sgn;
          bus.dividend   = $urandom;
          bus.divisor    = $urandom;
        end
        tick();
        idle_inputs();
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.hilo_q !== model_hilo) hold_bad++;
      if (bus.div_done !== 1'b0 || bus.div_by_zero !== 1'b0) done_bad++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy_window: %0d of 34 cycles not busy, expected 0", name, busy_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL %s_hold: hilo_q changed in %0d busy cycles, expected 0", name, hold_bad);
    end
    checks++;
    if (done_bad != 0) begin
      errors++;
      $display("FAIL %s_early_done: done/dbz high in %0d busy cycles, expected 0", name, done_bad);
    end
    tick();
    checks++;
    if (bus.hilo_q !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h expected %h", name, bus.hilo_q, exp);
    end
    checks++;
    if ({bus.busy, bus.div_done, bus.div_by_zero} !== {1'b0, 1'b1, (b == 32'h0)}) begin
      errors++;
      $display("FAIL %s_finish_flags: busy/done/dbz got %b%b%b expected 01%b", name,
               bus.busy, bus.div_done, bus.div_by_zero, (b == 32'h0));
    end
    model_hilo = exp;
    tick();
    checks++;
    if ({bus.div_done, bus.div_by_zero} !== 2'b00 || bus.hilo_q !== exp) begin
      errors++;
      $display("FAIL %s_pulse_end: done/dbz got %b%b hilo %h expected 00 and %h", name,
               bus.div_done, bus.div_by_zero, bus.hilo_q, exp);
    end
  endtask

  task automatic test_unsigned();
    do_divide("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    do_divide("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0);
    do_divide("sdiv_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b0, 1'b0);
    do_divide("udiv_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    do_divide("div0_55", 1'b0, 32'h55, 32'h0, {32'h00000055, 32'hFFFFFFFF}, 1'b0, 1'b0);
    do_divide("div0_signed_neg", 1'b1, 32'hFFFFFF00, 32'h0, {32'hFFFFFF00, 32'hFFFFFFFF}, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    logic [31:0] a;
    logic [31:0] b;
    do_divide("collide_busy", 1'b0, 32'd1000, 32'd3, ref_div(1'b0, 32'd1000, 32'd3), 1'b0, 1'b1);
    a = $urandom;
    b = $urandom_range(1, 5000);
    do_divide("wr_and_start", 1'b1, a, b, ref_div(1'b1, a, b), 1'b1, 1'b0);
  endtask

  task automatic test_random_div();
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    for (int i = 0; i < 12; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF - $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      do_divide("rand", sgn, a, b, ref_div(sgn, a, b), 1'b0, 1'b0);
    end
  endtask
`else
  task automatic test_div_ignored();
    logic        wr;
    logic [63:0] wd;
    for (int i = 0; i < 6; i++) begin
      wr = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      bus.wr_en      = wr;
      bus.wr_data    = wd;
      bus.start_div  = 1'b1;
      bus.div_signed = 1'($urandom_range(0, 1));
      bus.dividend   = $urandom;
      bus.divisor    = $urandom_range(0, 3);
      tick();
      idle_inputs();
      if (wr) model_hilo = wd;
      checks++;
      if (bus.hilo_q !== model_hilo) begin
        errors++;
        $display("FAIL nodiv_hilo[%0d]: got %h expected %h", i, bus.hilo_q, model_hilo);
      end
      tick();
      checks++;
      if ({bus.busy, bus.div_done, bus.div_by_zero} !== 3'b000) begin
        errors++;
        $display("FAIL nodiv_flags[%0d]: busy/done/dbz got %b%b%b expected 000", i,
                 bus.busy, bus.div_done, bus.div_by_zero);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [63:0] wd;
    wd = {$urandom, $urandom} | 64'h1;
    bus.wr_en   = 1'b1;
    bus.wr_data = wd;
    tick();
    idle_inputs();
    model_hilo = wd;
`ifdef HILO_ITER_DIV_EN
    bus.start_div = 1'b1;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom_range(1, 1000);
    tick();
    idle_inputs();
    repeat (21) tick();
`endif
    reset = 1'b0;
    #1;
    checks++;
    if (bus.hilo_q !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_hilo: got %h expected 0", bus.hilo_q);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b expected 0", bus.busy);
    end
    tick();
    reset = 1'b1;
    model_hilo = '0;
`ifdef HILO_ITER_DIV_EN
    begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom_range(1, 50000);
      do_divide("after_reset", 1'b1, a, b, ref_div(1'b1, a, b), 1'b1, 1'b0);
    end
`else
    wd = {$urandom, $urandom};
    bus.wr_en   = 1'b1;
    bus.wr_data = wd;
    tick();
    idle_inputs();
    model_hilo = wd;
    checks++;
    if (bus.hilo_q !== model_hilo) begin
      errors++;
      $display("FAIL after_reset_write: got %h expected %h", bus.hilo_q, model_hilo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
`ifdef HILO_ITER_DIV_EN
    test_unsigned();
    test_signed();
    test_div_zero();
    test_collision();
    test_reset_mid();
    test_random_div();
`else
    test_div_ignored();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
